// File: rtl/e_mdu.sv
// E-stage multiply/divide unit of the P7 pipelined MIPS core; owns HI/LO.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining E_MDU_MADD_EN.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] Out,
    output logic [31:0] HI_dbg,
    output logic [31:0] LO_dbg
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef E_MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic [31:0]       r_phi;
    logic [31:0]       r_plo;
    logic              r_pwr;
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;

    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [31:0]        w_divisor;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;
    logic [63:0]        w_result;
    logic               w_res_wr;
    logic               w_launch_op;
    logic [CNT_W-1:0]   w_cycles;
    logic               w_launch;

    // Signed product via sign extension; the low 64 bits are exact.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Substitute a divisor of 1 on divide-by-zero so the datapath never produces X.
    assign w_div_zero = (B == 32'd0);
    assign w_div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign w_divisor  = w_div_zero ? 32'd1 : B;
    assign w_q_s      = $signed(A) / $signed(w_divisor);
    assign w_r_s      = $signed(A) % $signed(w_divisor);
    assign w_q_u      = A / w_divisor;
    assign w_r_u      = A % w_divisor;

    // Decode of launchable ops, their latency and the pending 64-bit result.
    always_comb begin
        w_result    = 64'd0;
        w_res_wr    = 1'b1;
        w_launch_op = 1'b0;
        w_cycles    = CNT_W'(MULT_CYCLES);
        case (MDUOp)
            OP_MULT: begin
                w_launch_op = 1'b1;
                w_result    = w_prod_s;
            end
            OP_MULTU: begin
                w_launch_op = 1'b1;
                w_result    = w_prod_u;
            end
            OP_DIV: begin
                w_launch_op = 1'b1;
                w_cycles    = CNT_W'(DIV_CYCLES);
                w_res_wr    = !w_div_zero;
                w_result    = w_div_ovf ? {32'd0, 32'h8000_0000} : {w_r_s, w_q_s};
            end
            OP_DIVU: begin
                w_launch_op = 1'b1;
                w_cycles    = CNT_W'(DIV_CYCLES);
                w_res_wr    = !w_div_zero;
                w_result    = {w_r_u, w_q_u};
            end
`ifdef E_MDU_MADD_EN
            OP_MADD: begin
                w_launch_op = 1'b1;
                w_result    = {r_hi, r_lo} + w_prod_s;
            end
            OP_MADDU: begin
                w_launch_op = 1'b1;
                w_result    = {r_hi, r_lo} + w_prod_u;
            end
            OP_MSUB: begin
                w_launch_op = 1'b1;
                w_result    = {r_hi, r_lo} - w_prod_s;
            end
            OP_MSUBU: begin
                w_launch_op = 1'b1;
                w_result    = {r_hi, r_lo} - w_prod_u;
            end
`endif
            default: begin
                w_launch_op = 1'b0;
            end
        endcase
    end

    assign w_launch = Start && !Req && !r_busy && w_launch_op;

    // Launch captures the result; commit happens on the edge that ends the last busy cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_phi  <= 32'd0;
            r_plo  <= 32'd0;
            r_pwr  <= 1'b0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (w_launch) begin
            r_phi  <= w_result[63:32];
            r_plo  <= w_result[31:0];
            r_pwr  <= w_res_wr;
            r_cnt  <= w_cycles;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (r_pwr) begin
                    r_hi <= r_phi;
                    r_lo <= r_plo;
                end
            end
        end else if (!Req) begin
            if (MDUOp == OP_MTHI) r_hi <= A;
            if (MDUOp == OP_MTLO) r_lo <= A;
        end
    end

    // Zero-latency read path for mfhi/mflo.
    always_comb begin
        Out = 32'd0;
        if (MDUOp == OP_MFHI) Out = r_hi;
        if (MDUOp == OP_MFLO) Out = r_lo;
    end

    assign Busy   = r_busy;
    assign HI_dbg = r_hi;
    assign LO_dbg = r_lo;

endmodule
